// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - ALU self-test controller: sweeps ops 0..9 with directed and LFSR operands, checks a golden model.
// Optional ALU_BIST_MISR_EN adds a result signature output.
module alu_bist #(
  parameter int          VECTORS_PER_OP = 16,
  parameter logic [31:0] SEED           = 32'hACE12024,
  parameter int          ERR_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctrl,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_ctrl,
  output logic [31:0]      fail_a,
  output logic [31:0]      fail_b,
  output logic [31:0]      fail_result
`ifdef ALU_BIST_MISR_EN
  ,
  output logic [31:0]      signature
`endif
);

  localparam logic [31:0] TAPS = 32'h80200003;
  localparam int VW = (VECTORS_PER_OP > 1) ? $clog2(VECTORS_PER_OP) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [VW-1:0]    vec_q;
  logic [31:0]      lfsr_q;
  logic [31:0]      a_q, b_q;
  logic [3:0]       ctrl_q;
  logic             busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       fail_ctrl_q;
  logic [31:0]      fail_a_q, fail_b_q, fail_result_q;

  logic [31:0]      exp_result;
  logic             mismatch;
  logic [31:0]      lfsr_1, lfsr_2;
  logic             last_vec, last_op;
  logic [VW-1:0]    vec_d;
  logic [3:0]       op_d;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  always_comb begin
    exp_result = 32'd0;
    case (ctrl_q)
      4'd0: exp_result = a_q + b_q;
      4'd1: exp_result = a_q - b_q;
      4'd2: exp_result = a_q & b_q;
      4'd3: exp_result = a_q | b_q;
      4'd4: exp_result = a_q ^ b_q;
      4'd5: exp_result = a_q << b_q[4:0];
      4'd6: exp_result = a_q >> b_q[4:0];
      4'd7: exp_result = $unsigned($signed(a_q) >>> b_q[4:0]);
      4'd8: exp_result = {31'd0, $signed(a_q) < $signed(b_q)};
      4'd9: exp_result = {31'd0, a_q < b_q};
      default: exp_result = 32'd0;
    endcase
  end

  assign mismatch = (alu_result != exp_result) || (alu_zero != (exp_result == 32'd0));
  assign lfsr_1   = lfsr_next(lfsr_q);
  assign lfsr_2   = lfsr_next(lfsr_1);
  assign last_vec = (vec_q == VW'(VECTORS_PER_OP - 1));
  assign last_op  = (op_q == 4'd9);
  assign vec_d    = last_vec ? '0 : vec_q + 1'b1;
  assign op_d     = last_vec ? op_q + 4'd1 : op_q;

`ifdef ALU_BIST_MISR_EN
  logic [31:0] sig_q;
  assign signature = sig_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= 4'd0;
      vec_q         <= '0;
      lfsr_q        <= SEED;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      ctrl_q        <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= '0;
      fail_ctrl_q   <= 4'd0;
      fail_a_q      <= 32'd0;
      fail_b_q      <= 32'd0;
      fail_result_q <= 32'd0;
`ifdef ALU_BIST_MISR_EN
      sig_q         <= 32'd0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q       <= APPLY;
            op_q          <= 4'd0;
            vec_q         <= '0;
            lfsr_q        <= SEED;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            ctrl_q        <= 4'd0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= '0;
            fail_ctrl_q   <= 4'd0;
            fail_a_q      <= 32'd0;
            fail_b_q      <= 32'd0;
            fail_result_q <= 32'd0;
`ifdef ALU_BIST_MISR_EN
            sig_q         <= 32'd0;
`endif
          end
        end
        APPLY: state_q <= CHECK;
        CHECK: begin
          if (mismatch) begin
            if (!(&err_q)) err_q <= err_q + 1'b1;
            // err_count saturates and never returns to zero, so zero marks the first failure
            if (err_q == '0) begin
              fail_ctrl_q   <= ctrl_q;
              fail_a_q      <= a_q;
              fail_b_q      <= b_q;
              fail_result_q <= alu_result;
            end
          end
`ifdef ALU_BIST_MISR_EN
          sig_q <= {sig_q[30:0], ^(sig_q & TAPS)} ^ alu_result ^ {31'd0, alu_zero};
`endif
          if (last_vec && last_op) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0) && !mismatch;
          end else begin
            state_q <= APPLY;
            vec_q   <= vec_d;
            op_q    <= op_d;
            ctrl_q  <= op_d;
            if (last_vec) begin
              a_q <= 32'd0;
              b_q <= 32'd0;
            end else begin
              a_q    <= lfsr_q;
              b_q    <= lfsr_1;
              lfsr_q <= lfsr_2;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_ctrl    = ctrl_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_ctrl   = fail_ctrl_q;
  assign fail_a      = fail_a_q;
  assign fail_b      = fail_b_q;
  assign fail_result = fail_result_q;

endmodule

// File: tb/tb_alu_bist.sv
// tb/tb_alu_bist.sv - self-checking bench for alu_bist with a faultable ALU and a reference vector model.
// Covers the ALU_BIST_MISR_EN signature when that macro is defined.
module tb_alu_bist;

  localparam int          VPO  = 16;
  localparam int          NV   = 10 * VPO;
  localparam logic [31:0] SEED = 32'hACE12024;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] alu_a, alu_b, fail_a, fail_b, fail_result;
  logic [3:0]  alu_ctrl, fail_ctrl;
  logic        busy, done, pass;
  logic [15:0] err_count;
`ifdef ALU_BIST_MISR_EN
  logic [31:0] signature;
`endif

  int          fault_mode = 0;
  logic [3:0]  f_op = 4'd0;
  logic [31:0] f_a = 32'd0, f_b = 32'd0, f_mask = 32'd0;

  int          errors = 0;
  int          checks = 0;

  logic [31:0] ref_a [NV];
  logic [31:0] ref_b [NV];
  logic [3:0]  ref_c [NV];

  int          e_err;
  logic [3:0]  e_fc;
  logic [31:0] e_fa, e_fb, e_fr, e_sig;
  logic        e_pass;

  alu_bist #(.VECTORS_PER_OP(VPO), .SEED(SEED), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_ctrl(fail_ctrl), .fail_a(fail_a), .fail_b(fail_b), .fail_result(fail_result)
`ifdef ALU_BIST_MISR_EN
    , .signature(signature)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Mode 0 good ALU, 1 SUB bit0 stuck-at-1, 2 zero flag stuck-at-0, 3 bit flip on one chosen vector
  function automatic logic [32:0] alu_model(input int mode, input logic [3:0] fop, input logic [31:0] fa,
                                             input logic [31:0] fb, input logic [31:0] fm,
                                             input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        z;
    r = alu_fn(c, a, b);
    if (mode == 1 && c == 4'd1) r[0] = 1'b1;
    if (mode == 3 && c == fop && a == fa && b == fb) r = r ^ fm;
    z = (r == 32'd0);
    if (mode == 2) z = 1'b0;
    return {z, r};
  endfunction

  always_comb {alu_zero, alu_result} = alu_model(fault_mode, f_op, f_a, f_b, f_mask, alu_ctrl, alu_a, alu_b);

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_ref();
    logic [31:0] s;
    s = SEED;
    for (int op = 0; op < 10; op++) begin
      for (int v = 0; v < VPO; v++) begin
        ref_c[op*VPO+v] = 4'(op);
        if (v == 0) begin
          ref_a[op*VPO+v] = 32'd0;
          ref_b[op*VPO+v] = 32'd0;
        end else begin
          ref_a[op*VPO+v] = s;
          ref_b[op*VPO+v] = lfsr_step(s);
          s = lfsr_step(lfsr_step(s));
        end
      end
    end
  endtask

  task automatic compute_expect();
    logic [32:0] good, got;
    e_err = 0; e_fc = 4'd0; e_fa = 32'd0; e_fb = 32'd0; e_fr = 32'd0; e_sig = 32'd0;
    for (int i = 0; i < NV; i++) begin
      good = alu_model(0, f_op, f_a, f_b, f_mask, ref_c[i], ref_a[i], ref_b[i]);
      got  = alu_model(fault_mode, f_op, f_a, f_b, f_mask, ref_c[i], ref_a[i], ref_b[i]);
      if (good != got) begin
        if (e_err == 0) begin
          e_fc = ref_c[i]; e_fa = ref_a[i]; e_fb = ref_b[i]; e_fr = got[31:0];
        end
        e_err++;
      end
      e_sig = {e_sig[30:0], ^(e_sig & TAPS)} ^ got[31:0] ^ {31'd0, got[32]};
    end
    e_pass = (e_err == 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 68'({busy, done, pass}), 68'd0);
    check({tag, "_operands"}, {alu_ctrl, alu_a, alu_b}, 68'd0);
    check({tag, "_err"}, 68'(err_count), 68'd0);
    check({tag, "_fail_ab"}, {fail_ctrl, fail_a, fail_b}, 68'd0);
    check({tag, "_fail_result"}, 68'(fail_result), 68'd0);
  endtask

  task automatic run(input string tag, input int again_at, input int abort_at);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!done && cyc < 2000) begin
      if (cyc == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (busy) begin
        if (k % 2 == 0 && k / 2 < NV)
          check({tag, "_operands"}, {alu_ctrl, alu_a, alu_b}, {ref_c[k/2], ref_a[k/2], ref_b[k/2]});
        k++;
      end
      start = (cyc == again_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 68'(k), 68'(2 * NV));
    check({tag, "_flags"}, 68'({busy, done, pass}), 68'({1'b0, 1'b1, e_pass}));
    check({tag, "_err"}, 68'(err_count), 68'(e_err));
    check({tag, "_fail_ab"}, {fail_ctrl, fail_a, fail_b}, {e_fc, e_fa, e_fb});
    check({tag, "_fail_result"}, 68'(fail_result), 68'(e_fr));
`ifdef ALU_BIST_MISR_EN
    check({tag, "_signature"}, 68'(signature), 68'(e_sig));
`endif
  endtask

  initial begin
    int idx;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");
    build_ref();

    fault_mode = 0;
    compute_expect();
    run("good", -1, -1);
    run("good_again", -1, -1);
    run("restart_ignored", 50, -1);
    run("abort", -1, 100);
    check_all_zero("mid_run_reset");
    run("after_reset", -1, -1);

    fault_mode = 1;
    compute_expect();
    run("sub_bit0", -1, -1);

    fault_mode = 2;
    compute_expect();
    run("zero_stuck", -1, -1);

    fault_mode = 3;
    for (int t = 0; t < 3; t++) begin
      f_op   = 4'($urandom_range(0, 9));
      idx    = int'(f_op) * VPO + int'($urandom_range(0, VPO - 1));
      f_a    = ref_a[idx];
      f_b    = ref_b[idx];
      f_mask = 32'd1 << $urandom_range(0, 31);
      compute_expect();
      run("bitflip", -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
